// File: rtl/fifo_rd_uart_tx.sv
// fifo_rd_uart_tx: read-domain consumer of the async FIFO. Pops one word per
// frame and serialises it as start / data (LSB first) / optional parity / stop.
//
// Handshake: the FIFO presents a valid head word whenever rempty=0. rinc is the
// transfer strobe: one word moves on every rising rclk edge that ends a cycle
// with rinc=1, and rinc is only raised while rempty=0, so it never under-reads.
module fifo_rd_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  tx_en,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;

  logic last_cycle;
  logic pop;

  assign last_cycle = (cnt_q == CNT_LAST);

  // A word is taken when idle, or in the final stop cycle so frames abut.
  assign pop = tx_en & ~rempty & ~rrst &
               ((state_q == IDLE) | ((state_q == STOP) & last_cycle));

  // State, counters and frame contents; everything clears on reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Next-state logic: each non-idle state spans one full bit period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    if (state_q != IDLE) begin
      cnt_d = last_cycle ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: ;
      START: begin
        if (last_cycle) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (last_cycle) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (last_cycle) state_d = STOP;
      end
      STOP: begin
        if (last_cycle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Loading a word overrides the idle/stop transition above.
    if (pop) begin
      state_d   = START;
      cnt_d     = '0;
      bit_d     = '0;
      shift_d   = rdata;
      par_en_d  = par_en;
      par_bit_d = (^rdata) ^ par_typ;
    end
  end

  // Outputs decoded from registered state only, so the line never glitches.
  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      PARITY:  tx_out = par_bit_q;
      default: tx_out = 1'b1;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == STOP) & last_cycle;
  assign rinc        = pop;
  assign dbg_state_o = state_q;

endmodule
